// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the radix-2 butterfly stage and its controller.
package fft_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned FRAC_DEF   = 6;
   localparam int unsigned ADDR_W     = 4;
   localparam int unsigned N_REGS     = 10;

   localparam logic [ADDR_W-1:0] REW = 4'd0;
   localparam logic [ADDR_W-1:0] IMW = 4'd1;
   localparam logic [ADDR_W-1:0] REB = 4'd2;
   localparam logic [ADDR_W-1:0] IMB = 4'd3;
   localparam logic [ADDR_W-1:0] REA = 4'd4;
   localparam logic [ADDR_W-1:0] IMA = 4'd5;
   localparam logic [ADDR_W-1:0] REY = 4'd6;
   localparam logic [ADDR_W-1:0] IMY = 4'd7;
   localparam logic [ADDR_W-1:0] REZ = 4'd8;
   localparam logic [ADDR_W-1:0] IMZ = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL0,
      ST_MUL1,
      ST_MUL2,
      ST_MUL3,
      ST_ADD,
      ST_DONE
   } state_e;

   typedef logic signed [DATA_W_DEF-1:0]   data_t;
   typedef logic signed [2*DATA_W_DEF-1:0] prod_t;

   // Clamp a wide signed value into the range of a w-bit two's complement number.
   function automatic logic signed [63:0] sat(input logic signed [63:0] x,
                                              input int unsigned       w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi)      sat = hi;
      else if (x < lo) sat = lo;
      else             sat = x;
   endfunction

endpackage

// File: rtl/bf_mult.sv
// Registered signed multiplier; operand selection lives in the caller so this can be swapped for a DSP/pipelined core.
module bf_mult
   import fft_pkg::*;
#(
   parameter int unsigned W = DATA_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic signed [W-1:0]   a,
   input  logic signed [W-1:0]   b,
   output logic signed [2*W-1:0] p
);

   localparam int unsigned PW = 2 * W;

   logic signed [PW-1:0] p_d;
   logic signed [PW-1:0] p_q;

   always_comb begin
      p_d = p_q;
      if (en) p_d = PW'(a) * PW'(b);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) p_q <= '0;
      else     p_q <= p_d;
   end

   assign p = p_q;

endmodule

// File: rtl/butterfly_datapath.sv
// Radix-2 butterfly Y = A + W*B, Z = A - W*B using one time-shared multiplier over four cycles.
module butterfly_datapath
   import fft_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned FRAC   = FRAC_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic [3:0]        addra,
   input  logic              reg_WEN,
   input  logic              cal_flag,
   input  logic [3:0]        addr_led,
   output logic [DATA_W-1:0] led_data,
   output logic              Ready_dis,
   output logic              reg_finish,
   output logic              reg_add_finish
);

   localparam int unsigned PW = 2 * DATA_W;
   localparam int unsigned SW = PW + 1;

   state_e state_q, state_d;

   logic signed [DATA_W-1:0] regs_q [N_REGS];
   logic signed [DATA_W-1:0] regs_d [N_REGS];
   logic signed [PW-1:0]     p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
   logic                     ready_dis_q, ready_dis_d;
   logic                     reg_finish_q, reg_finish_d;
   logic                     reg_add_finish_q, reg_add_finish_d;

   logic                     mult_en;
   logic signed [DATA_W-1:0] mult_a, mult_b;
   logic signed [PW-1:0]     mult_p;

   logic signed [SW-1:0]     wr, wi;
   logic signed [SW:0]       y_re, y_im, z_re, z_im;

   bf_mult #(.W(DATA_W)) u_mult (
      .clk (clk),
      .rst (rst),
      .en  (mult_en),
      .a   (mult_a),
      .b   (mult_b),
      .p   (mult_p)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (cal_flag) state_d = ST_MUL0;
         ST_MUL0: state_d = ST_MUL1;
         ST_MUL1: state_d = ST_MUL2;
         ST_MUL2: state_d = ST_MUL3;
         ST_MUL3: state_d = ST_ADD;
         ST_ADD:  state_d = ST_DONE;
         ST_DONE: if (!cal_flag) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Twiddle product terms; mult_p still holds p3 during ADD.
   always_comb begin
      wr   = (SW'(p0_q) - SW'(p1_q)) >>> FRAC;
      wi   = (SW'(p2_q) + SW'(mult_p)) >>> FRAC;
      y_re = (SW+1)'(regs_q[REA]) + (SW+1)'(wr);
      y_im = (SW+1)'(regs_q[IMA]) + (SW+1)'(wi);
      z_re = (SW+1)'(regs_q[REA]) - (SW+1)'(wr);
      z_im = (SW+1)'(regs_q[IMA]) - (SW+1)'(wi);
   end

   always_comb begin
      regs_d           = regs_q;
      p0_d             = p0_q;
      p1_d             = p1_q;
      p2_d             = p2_q;
      mult_en          = 1'b0;
      mult_a           = '0;
      mult_b           = '0;
      reg_finish_d     = 1'b0;
      reg_add_finish_d = 1'b0;
      ready_dis_d      = (state_d == ST_DONE);
      unique case (state_q)
         ST_IDLE: if (reg_WEN && (addra <= IMA)) regs_d[addra] = data_in;
         ST_MUL0: begin
            mult_en = 1'b1;
            mult_a  = regs_q[REW];
            mult_b  = regs_q[REB];
         end
         ST_MUL1: begin
            p0_d    = mult_p;
            mult_en = 1'b1;
            mult_a  = regs_q[IMW];
            mult_b  = regs_q[IMB];
         end
         ST_MUL2: begin
            p1_d    = mult_p;
            mult_en = 1'b1;
            mult_a  = regs_q[REW];
            mult_b  = regs_q[IMB];
         end
         ST_MUL3: begin
            p2_d         = mult_p;
            mult_en      = 1'b1;
            mult_a       = regs_q[IMW];
            mult_b       = regs_q[REB];
            reg_finish_d = 1'b1;
         end
         ST_ADD: begin
            regs_d[REY]      = DATA_W'(sat(64'(y_re), DATA_W));
            regs_d[IMY]      = DATA_W'(sat(64'(y_im), DATA_W));
            regs_d[REZ]      = DATA_W'(sat(64'(z_re), DATA_W));
            regs_d[IMZ]      = DATA_W'(sat(64'(z_im), DATA_W));
            reg_add_finish_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
         p0_q             <= '0;
         p1_q             <= '0;
         p2_q             <= '0;
         ready_dis_q      <= 1'b0;
         reg_finish_q     <= 1'b0;
         reg_add_finish_q <= 1'b0;
      end else begin
         regs_q           <= regs_d;
         p0_q             <= p0_d;
         p1_q             <= p1_d;
         p2_q             <= p2_d;
         ready_dis_q      <= ready_dis_d;
         reg_finish_q     <= reg_finish_d;
         reg_add_finish_q <= reg_add_finish_d;
      end
   end

   assign led_data       = (addr_led < 4'(N_REGS)) ? regs_q[addr_led] : '0;
   assign Ready_dis      = ready_dis_q;
   assign reg_finish     = reg_finish_q;
   assign reg_add_finish = reg_add_finish_q;

endmodule

// File: tb/tb_butterfly_datapath.sv
// Randomised and directed checks of butterfly_datapath against an integer reference model.
module tb_butterfly_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic [3:0] addra;
   logic       reg_WEN;
   logic       cal_flag;
   logic [3:0] addr_led;
   logic [7:0] led_data;
   logic       Ready_dis;
   logic       reg_finish;
   logic       reg_add_finish;

   int n_chk  = 0;
   int n_pass = 0;
   int m [10];

   butterfly_datapath #(.DATA_W(8), .FRAC(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .data_in        (data_in),
      .addra          (addra),
      .reg_WEN        (reg_WEN),
      .cal_flag       (cal_flag),
      .addr_led       (addr_led),
      .led_data       (led_data),
      .Ready_dis      (Ready_dis),
      .reg_finish     (reg_finish),
      .reg_add_finish (reg_add_finish)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int a, output int v);
      addr_led = 4'(a);
      #1;
      v = int'($signed(led_data));
   endtask

   function automatic int clamp(input int x);
      if (x > 127)  return 127;
      if (x < -128) return -128;
      return x;
   endfunction

   // Model: complex multiply, floor divide by 64 of each real/imag part, then saturating add/sub.
   function automatic void model_calc();
      int wr, wi;
      wr = (m[0] * m[2] - m[1] * m[3]) >>> 6;
      wi = (m[0] * m[3] + m[1] * m[2]) >>> 6;
      m[6] = clamp(m[4] + wr);
      m[7] = clamp(m[5] + wi);
      m[8] = clamp(m[4] - wr);
      m[9] = clamp(m[5] - wi);
   endfunction

   task automatic wr_reg(input int a, input int v);
      reg_WEN = 1'b1;
      addra   = 4'(a);
      data_in = 8'(v);
      tick();
      reg_WEN = 1'b0;
      if (a <= 5) m[a] = v;
   endtask

   task automatic check_all(input string tag);
      int v;
      for (int i = 0; i < 10; i++) begin
         rd(i, v);
         chk($sformatf("%s reg%0d", tag, i), v, m[i]);
      end
   endtask

   // Starts a computation (optionally writing sw_addr on the request edge and mid_addr during MUL2).
   task automatic run_calc(input string tag, input int sw_addr, input int sw_val,
                           input int mid_addr, input int mid_val);
      int rf_at = 0, rd_at = 0, raf_at = 0;
      cal_flag = 1'b1;
      if (sw_addr >= 0) begin
         reg_WEN = 1'b1; addra = 4'(sw_addr); data_in = 8'(sw_val);
         m[sw_addr] = sw_val;
      end
      tick();
      reg_WEN = 1'b0;
      for (int c = 1; c <= 8 && rd_at == 0; c++) begin
         if (c == 3 && mid_addr >= 0) begin
            reg_WEN = 1'b1; addra = 4'(mid_addr); data_in = 8'(mid_val);
         end
         tick();
         reg_WEN = 1'b0;
         if (reg_finish && rf_at == 0)      rf_at = c;
         if (reg_add_finish && raf_at == 0) raf_at = c;
         if (Ready_dis) rd_at = c;
      end
      chk({tag, " reg_finish cycle"}, rf_at, 4);
      chk({tag, " ready cycle"}, rd_at, 5);
      chk({tag, " add_finish cycle"}, raf_at, 5);
      model_calc();
      check_all(tag);
      tick();
      chk({tag, " add_finish one pulse"}, int'(reg_add_finish), 0);
      chk({tag, " ready held"}, int'(Ready_dis), 1);
      cal_flag = 1'b0;
      tick();
      chk({tag, " ready drop"}, int'(Ready_dis), 0);
      tick();
   endtask

   task automatic load6(input int rw, iw, rb, ib, ra, ia);
      wr_reg(0, rw); wr_reg(1, iw); wr_reg(2, rb);
      wr_reg(3, ib); wr_reg(4, ra); wr_reg(5, ia);
   endtask

   initial begin
      int v;
      rst = 1'b1; data_in = '0; addra = '0; reg_WEN = 1'b0; cal_flag = 1'b0; addr_led = '0;
      foreach (m[i]) m[i] = 0;

      // Writes during reset must be dropped.
      reg_WEN = 1'b1; addra = 4'd0; data_in = 8'd55;
      tick(); tick();
      reg_WEN = 1'b0;
      rd(0, v);
      chk("reset write ignored", v, 0);
      chk("reset ready", int'(Ready_dis), 0);
      rst = 1'b0;
      tick();
      check_all("reset");

      load6(64, 0, 32, 0, 16, 0);
      run_calc("basic", -1, 0, -1, 0);
      chk("basic rey", m[6], 48);

      load6(0, 64, 32, 16, 0, 0);
      run_calc("imagw", -1, 0, -1, 0);

      load6(64, 0, 64, 0, 127, 0);
      run_calc("satpos", -1, 0, -1, 0);
      load6(64, 0, 64, 0, -128, 0);
      run_calc("satneg", -1, 0, -1, 0);

      // Write during MUL2 is ignored.
      load6(64, 0, 32, 0, 16, 0);
      run_calc("midwr", -1, 0, 4, 5);
      rd(4, v);
      chk("midwr rea kept", v, 16);

      // Unused addresses and result addresses are not writable.
      wr_reg(6, 99);
      wr_reg(12, 77);
      for (int a = 10; a < 16; a++) begin
         rd(a, v);
         chk($sformatf("unused addr %0d", a), v, 0);
      end
      rd(6, v);
      chk("result not writable", v, m[6]);

      // Reset during MUL3 clears everything and suppresses the result write.
      cal_flag = 1'b1;
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      #1;
      rd(6, v);
      chk("midrst rey", v, 0);
      chk("midrst ready", int'(Ready_dis), 0);
      chk("midrst add_finish", int'(reg_add_finish), 0);
      cal_flag = 1'b0;
      tick();
      rst = 1'b0;
      foreach (m[i]) m[i] = 0;
      tick();
      check_all("after rst");
      load6(64, 0, 32, 0, 16, 0);
      run_calc("fresh", -1, 0, -1, 0);

      // Random operands, alternately loading the last operand on the request edge.
      for (int it = 0; it < 20; it++) begin
         int vals [6];
         foreach (vals[i]) vals[i] = int'($urandom_range(255)) - 128;
         for (int i = 0; i < 5; i++) wr_reg(i, vals[i]);
         if (it[0]) run_calc($sformatf("rnd%0d", it), 5, vals[5], -1, 0);
         else begin
            wr_reg(5, vals[5]);
            run_calc($sformatf("rnd%0d", it), -1, 0, -1, 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/butterfly_datapath.md
# butterfly_datapath

Radix-2 butterfly arithmetic stage driven by the FFT `controller`. It holds the six operand registers (ReW, ImW, ReB, ImB, ReA, ImA), which the controller loads through `addra`/`reg_WEN`. On `cal_flag` it computes Y = A + W·B and Z = A − W·B with one time-shared multiplier. It then raises `Ready_dis` and serves operands and results to the LED display path through `addr_led`.

## Interface
Parameters:
- `DATA_W`, default 8: operand/result width, signed two's complement.
- `FRAC`, default 6: fractional bits (1.0 = 64 at defaults).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `data_in` in DATA_W: operand write data.
- `addra` in 4: operand write address.
- `reg_WEN` in 1: operand write enable.
- `cal_flag` in 1: compute request from controller, level.
- `addr_led` in 4: display read address.
- `led_data` out DATA_W: display read data, combinational from `addr_led`.
- `Ready_dis` out 1: results valid; held until `cal_flag` drops.
- `reg_finish` out 1: one-cycle pulse when all four products are registered.
- `reg_add_finish` out 1: one-cycle pulse when Y/Z are written.

## Operation
- Address map (shared constants): Rew=0, Imw=1, Reb=2, Imb=3, Rea=4, Ima=5, Rey=6, Imy=7, Rez=8, Imz=9; 10–15 unused.
- Writes:
  - Accepted only in IDLE with `reg_WEN`=1 and `addra`≤5.
  - Writes to any other address, or in any other state, are ignored.
- Read:
  - `led_data` returns the register at `addr_led` (0–9).
  - Addresses 10–15 return 0.
- FSM states: IDLE, MUL0, MUL1, MUL2, MUL3, ADD, DONE.
  - IDLE → MUL0 when `cal_flag`=1.
  - MUL0→MUL1→MUL2→MUL3→ADD→DONE, unconditional, one cycle each.
  - DONE → IDLE when `cal_flag`=0.
  - `cal_flag` dropping before DONE is ignored; the computation completes, then DONE exits on the next cycle.
- Products: one DATA_W×DATA_W signed multiply per MUL state, result registered at 2·DATA_W bits.
  - MUL0: p0 = ReW·ReB
  - MUL1: p1 = ImW·ImB
  - MUL2: p2 = ReW·ImB
  - MUL3: p3 = ImW·ReB
- ADD state:
  - wr = (p0 − p1) >>> FRAC, wi = (p2 + p3) >>> FRAC. Computed at 2·DATA_W+1 bits; arithmetic shift, truncation toward −∞.
  - Rey = sat(ReA + wr), Imy = sat(ImA + wi), Rez = sat(ReA − wr), Imz = sat(ImA − wi).
  - sat clamps to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- Operand registers are never modified by computation.
- Result registers hold their values until the next ADD or reset.

## Timing
- Reset values:
  - State IDLE.
  - All ten data registers and p0–p3 = 0.
  - `Ready_dis`, `reg_finish`, `reg_add_finish` = 0.
- Let edge 0 be the edge that samples `cal_flag`=1 in IDLE.
  - Edge 1: p0 registered. Edge 2: p1. Edge 3: p2. Edge 4: p3.
  - `reg_finish` = 1 during the ADD cycle (after edge 4).
  - Edge 5: results registered.
  - `reg_add_finish` = 1 and `Ready_dis` = 1 from edge 5 (DONE).
  - Latency from request to `Ready_dis`: 5 cycles.
- `Ready_dis` is registered. It deasserts on the first edge that samples `cal_flag`=0 in DONE.
- Write and request on the same cycle in IDLE: the write is committed at that edge and the computation starts next cycle. MUL0 therefore uses the new value.
- Reset mid-operation: returns to IDLE immediately. Operands, results and flags are cleared, with no partial result write.
- Back-to-back: a new `cal_flag` rise is honoured only after at least one cycle in IDLE.

## Structure
- Package `fft_pkg`:
  - Address constants (Rew…Imz).
  - State enum typedef.
  - Signed data/product typedefs parameterised by DATA_W.
  - A saturate function.
- One sub-module `bf_mult`: registered signed multiplier (operand-select muxes outside). This isolates the future pipelined/DSP replacement.
- Operand/result storage: a 10-entry register array inside `butterfly_datapath`.

## Test plan
1. Reset with `rst`=1 → all `led_data` reads 0, `Ready_dis`=0; writes while `rst`=1 are ignored.
2. Load W=(64,0), B=(32,0), A=(16,0), pulse `cal_flag` → `reg_finish` after 4 cycles, `Ready_dis` at cycle 5; Rey=48, Imy=0, Rez=−16, Imz=0.
3. Load W=(0,64), B=(32,16), A=(0,0) → Rey=−16, Imy=32, Rez=16, Imz=−32.
4. Saturation: W=(64,0), B=(64,0), A=(127,0) → Rey=127, Rez=63. With A=(−128,0) → Rey=−64, Rez=−128.
5. Write ReA=5 during MUL2 → ignored; read addr 4 returns the old value; results use the old value.
6. Assert `rst` in MUL3 after a prior result Rey=48 → IDLE, Rey reads 0, no `reg_add_finish`. A fresh run then completes in 5 cycles.
